// File: rtl/network_tb_pkg.sv
// Shared types and helpers for the per-port traffic checker: FSM encoding,
// the deterministic data pattern and the saturating statistics counter.
package network_tb_pkg;

    localparam int COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WGAP,
        ST_READ,
        ST_RWAIT,
        ST_CHECK,
        ST_DONE
    } ntc_state_e;

    // Computed wide; callers truncate to their own data width, which gives the modulo.
    function automatic logic [63:0] pattern_word(input logic [63:0] seed,
                                                 input logic [63:0] index,
                                                 input logic [63:0] pass);
        return seed + index + pass;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ntc_timeout_counter.sv
// Loadable down-counter with a terminal flag; used for both the issue gap
// and the read timeout waits of the traffic checker.
module ntc_timeout_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/network_port_traffic_checker.sv
// Self-checking traffic engine for one network port: writes a seeded pattern
// into its address window, reads it back and counts mismatches and timeouts.
module network_port_traffic_checker
    import network_tb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 16,
    parameter int SEED       = 'h5A,
    parameter int MODE       = 0,
    parameter int ISSUE_GAP  = 1,
    parameter int TIMEOUT    = 64,
    parameter int NUM_PASSES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [ADDR_WIDTH-1:0]  destinationAddressOut,
    output logic                   readOut,
    output logic                   writeOut,
    output logic [DATA_WIDTH-1:0]  dataOut,
    input  logic                   readReadyIn,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] errorCount,
    output logic [COUNT_WIDTH-1:0] opCount
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
    localparam logic [7:0]    LAST_PASS = 8'(NUM_PASSES - 1);

    ntc_state_e            state, state_next;
    logic [IW-1:0]         idx, idx_next;
    logic [7:0]            pass_cnt, pass_next;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] expected;
    logic                  gap_load, gap_tc, to_load, to_tc;
    logic                  write_done, check_done, accept_start;

    assign expected = DATA_WIDTH'(pattern_word(64'(SEED), 64'(idx), 64'(pass_cnt)));

    ntc_timeout_counter #(.WIDTH(4)) u_gap (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .enable     (state == ST_WGAP),
        .load_value (4'(ISSUE_GAP - 1)),
        .terminal   (gap_tc)
    );

    // Loaded with TIMEOUT-1 so that RWAIT lasts exactly TIMEOUT cycles without a response.
    ntc_timeout_counter #(.WIDTH(TW)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .enable     (state == ST_RWAIT),
        .load_value (TW'(TIMEOUT - 1)),
        .terminal   (to_tc)
    );

    assign accept_start = start && (state == ST_IDLE || state == ST_DONE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        idx_next   = idx;
        pass_next  = pass_cnt;
        gap_load   = 1'b0;
        to_load    = 1'b0;
        write_done = 1'b0;
        check_done = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_WRITE;
                    idx_next   = '0;
                    pass_next  = '0;
                end
            end
            ST_WRITE: begin
                if (ISSUE_GAP > 0) begin
                    state_next = ST_WGAP;
                    gap_load   = 1'b1;
                end else begin
                    write_done = 1'b1;
                end
            end
            ST_WGAP:  write_done = gap_tc;
            ST_READ: begin
                state_next = ST_RWAIT;
                to_load    = 1'b1;
            end
            ST_RWAIT: begin
                if (readReadyIn || to_tc) state_next = ST_CHECK;
            end
            ST_CHECK: check_done = 1'b1;
            default:  state_next = ST_IDLE;
        endcase

        if (write_done) begin
            if (MODE == 1) begin
                state_next = ST_READ;
            end else if (idx == LAST_IDX) begin
                state_next = ST_READ;
                idx_next   = '0;
            end else begin
                state_next = ST_WRITE;
                idx_next   = idx + 1'b1;
            end
        end

        if (check_done) begin
            if (idx == LAST_IDX) begin
                idx_next = '0;
                if (pass_cnt == LAST_PASS) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_WRITE;
                    pass_next  = pass_cnt + 1'b1;
                end
            end else begin
                idx_next   = idx + 1'b1;
                state_next = (MODE == 1) ? ST_WRITE : ST_READ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            pass_cnt   <= '0;
            rd_data    <= '0;
            timed_out  <= 1'b0;
            error      <= 1'b0;
            errorCount <= '0;
            opCount    <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            pass_cnt <= pass_next;

            if (accept_start) begin
                error      <= 1'b0;
                errorCount <= '0;
                opCount    <= '0;
            end

            // A response arriving in the final wait cycle wins over the timeout.
            if (state == ST_RWAIT) begin
                if (readReadyIn) begin
                    rd_data   <= dataIn;
                    timed_out <= 1'b0;
                end else if (to_tc) begin
                    timed_out  <= 1'b1;
                    error      <= 1'b1;
                    errorCount <= sat_inc(errorCount);
                end
            end

            if (state == ST_CHECK) begin
                opCount <= opCount + 1'b1;
                if (!timed_out && rd_data != expected) begin
                    error      <= 1'b1;
                    errorCount <= sat_inc(errorCount);
                end
            end
        end
    end

    assign writeOut = (state == ST_WRITE);
    assign readOut  = (state == ST_READ);
    assign busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign done     = (state == ST_DONE);
    assign destinationAddressOut = (writeOut || readOut)
                                 ? ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx) : '0;
    assign dataOut  = writeOut ? expected : '0;

endmodule
